// File: rtl/slow_tick_pkg.sv
// Shared BCD types and constants for the slow-tick counter.
package slow_tick_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Out-of-range BCD codes (A..F) collapse to zero.
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return (d > BCD_MAX) ? bcd_digit_t'(0) : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with load, up/down step and a wrap-pending indication.
module bcd_digit
    import slow_tick_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             up_down,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    bcd_digit_t digit_nxt;

    // Digit would wrap on the next step in the current direction.
    assign carry_out = up_down ? (digit == BCD_MAX) : (digit == bcd_digit_t'(0));

    // Next digit value: load beats step beats hold.
    always_comb begin
        digit_nxt = digit;
        if (load) begin
            digit_nxt = bcd_sanitize(load_digit);
        end else if (step) begin
            if (up_down) begin
                digit_nxt = carry_out ? bcd_digit_t'(0) : digit + bcd_digit_t'(1);
            end else begin
                digit_nxt = carry_out ? BCD_MAX : digit - bcd_digit_t'(1);
            end
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= '0;
        end else begin
            digit <= digit_nxt;
        end
    end

endmodule

// File: rtl/slow_tick_bcd_counter.sv
// Samples the divided slow clock as data, detects rising edges and steps a
// multi-digit BCD up/down counter once per edge.
module slow_tick_bcd_counter
    import slow_tick_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  slow_clk_in,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  carry
);

    localparam int unsigned CNT_W = BCD_W * DIGITS;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sampled;
    logic                   sample_valid;
    logic                   prev_q;
    logic                   armed_q;
    logic                   rise_q;
    logic                   step;
    logic                   step_acc;
    logic                   wrap;
    logic [DIGITS-1:0]      step_vec;
    logic [DIGITS-1:0]      carry_vec;
    logic [CNT_W-1:0]       count_int;

    assign sampled      = sync_q[SYNC_STAGES-1];
    // The sampled level is meaningless until the chain has filled with real input.
    assign sample_valid = fill_q[SYNC_STAGES-1];

    // Synchroniser plus a fill marker that tracks when the sampled level is genuine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Edge history, arming on first genuine low level, registered rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            prev_q  <= sampled;
            armed_q <= armed_q | (sample_valid & ~sampled);
            rise_q  <= armed_q & sampled & ~prev_q;
        end
    end

    // A load on the stepping cycle swallows the step.
    assign step = rise_q & enable & ~load;

    // Ripple step enables: digit i steps only when all lower digits wrap.
    always_comb begin
        step_vec = '0;
        step_acc = step;
        for (int i = 0; i < int'(DIGITS); i++) begin
            step_vec[i] = step_acc;
            step_acc    = step_acc & carry_vec[i];
        end
        wrap = step_acc;
    end

    genvar g;
    generate
        for (g = 0; g < int'(DIGITS); g++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .reset      (reset),
                .step       (step_vec[g]),
                .up_down    (up_down),
                .load       (load),
                .load_digit (load_value[g*BCD_W +: BCD_W]),
                .digit      (count_int[g*BCD_W +: BCD_W]),
                .carry_out  (carry_vec[g])
            );
        end
    endgenerate

    assign count = count_int;

    // One-cycle tick per detected edge and carry on a full-width wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick  <= 1'b0;
            carry <= 1'b0;
        end else begin
            tick  <= rise_q;
            carry <= wrap;
        end
    end

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// Scoreboard bench for slow_tick_bcd_counter.
module tb_slow_tick_bcd_counter;

    localparam int unsigned DIGITS = 4;
    localparam int MOD = 10000;

    typedef struct {
        logic [15:0] count;
        logic        carry;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        slow_clk_in = 1'b0;
    logic        enable = 1'b0;
    logic        up_down = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic [15:0] count;
    logic        tick;
    logic        carry;

    exp_t sb[$];
    exp_t mon_e;
    int   model = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    slow_tick_bcd_counter #(.DIGITS(DIGITS), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .slow_clk_in (slow_clk_in),
        .enable      (enable),
        .up_down     (up_down),
        .load        (load),
        .load_value  (load_value),
        .count       (count),
        .tick        (tick),
        .carry       (carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int v;
        int d;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(lv[i*4 +: 4]);
            if (d > 9) d = 0;
            v = v * 10 + d;
        end
        return v;
    endfunction

    // Scoreboard consumer: every tick must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (tick) begin
                if (sb.size() == 0) begin
                    check("unexpected_tick", 32'(tick), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("tick_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("count", 32'(count), 32'(mon_e.count));
                    check("carry", 32'(carry), 32'(mon_e.carry));
                end
            end else if (carry) begin
                check("carry_without_tick", 32'(carry), 32'd0);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance the reference value for one detected edge.
    task automatic model_step(output logic c);
        c = 1'b0;
        if (enable) begin
            if (up_down) begin
                c = (model == MOD - 1);
                model = (model + 1) % MOD;
            end else begin
                c = (model == 0);
                model = (model == 0) ? MOD - 1 : model - 1;
            end
        end
    endtask

    // One slow-clock period (3 high, 3 low) with its expected outcome queued.
    task automatic pulse();
        exp_t e;
        logic c;
        slow_clk_in = 1'b1;
        model_step(c);
        e.count = to_bcd(model);
        e.carry = c;
        e.cyc   = cyc + 4;
        sb.push_back(e);
        wait_neg(3);
        slow_clk_in = 1'b0;
        wait_neg(3);
    endtask

    task automatic do_load(input logic [15:0] lv);
        load = 1'b1;
        load_value = lv;
        wait_neg(1);
        load = 1'b0;
        model = from_load(lv);
        check("load_count", 32'(count), 32'(to_bcd(model)));
    endtask

    // Rising edge whose stepping cycle coincides with a load.
    task automatic pulse_with_load(input logic [15:0] lv);
        exp_t e;
        int c0;
        slow_clk_in = 1'b1;
        c0 = cyc;
        wait_neg(3);
        load = 1'b1;
        load_value = lv;
        model = from_load(lv);
        e.count = to_bcd(model);
        e.carry = 1'b0;
        e.cyc   = c0 + 4;
        sb.push_back(e);
        wait_neg(1);
        load = 1'b0;
        slow_clk_in = 1'b0;
        wait_neg(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int c0;
        int budget;

        // 1: slow clock high through reset release must not count
        reset = 1'b0;
        slow_clk_in = 1'b1;
        enable = 1'b0;
        wait_neg(3);
        check("reset_count", 32'(count), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        reset = 1'b1;
        wait_neg(10);
        check("no_tick_high_at_release", 32'(tick), 32'd0);
        check("count_after_release", 32'(count), 32'd0);
        slow_clk_in = 1'b0;
        wait_neg(4);
        pulse();
        check("count_hold_test1", 32'(count), 32'd0);

        // 2: twelve increments
        enable = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 12; i++) pulse();
        check("count_0012", 32'(count), 32'h0012);

        // 3: up wrap
        do_load(16'h9998);
        pulse();
        pulse();
        check("count_up_wrap", 32'(count), 32'h0000);

        // 4: down wrap then plain borrow
        do_load(16'h0000);
        up_down = 1'b0;
        pulse();
        pulse();
        check("count_down", 32'(count), 32'h9998);

        // 5: invalid digit sanitised, then load coincident with a rise
        do_load(16'h1A37);
        check("sanitised_load", 32'(count), 32'h1037);
        up_down = 1'b1;
        pulse_with_load(16'h1A37);
        check("load_beats_step", 32'(count), 32'h1037);

        // 6: hold with enable low, then reset mid-run
        do_load(16'h0455);
        pulse();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) pulse();
        check("count_held_0456", 32'(count), 32'h0456);

        slow_clk_in = 1'b1;
        c0 = cyc;
        e.count = 16'h0456;
        e.carry = 1'b0;
        e.cyc   = c0 + 4;
        sb.push_back(e);
        wait_neg(4);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_count", 32'(count), 32'd0);
        check("async_reset_tick", 32'(tick), 32'd0);
        check("async_reset_carry", 32'(carry), 32'd0);
        slow_clk_in = 1'b0;
        model = 0;
        wait_neg(2);
        reset = 1'b1;
        wait_neg(6);
        enable = 1'b1;
        up_down = 1'b1;
        pulse();
        check("count_after_rearm", 32'(count), 32'h0001);

        // Drain scoreboard with a bounded wait
        budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            wait_neg(1);
            budget--;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
